alu_exec_unit: RTL
==================

# alu_exec_unit

Multi-cycle execute/writeback stage sitting directly upstream of the 16×8 two-read/one-write register file (`Reg_File_2R1W`). It accepts one decoded instruction per handshake, drives the register file read addresses, latches the operands, and computes an 8-bit ALU result and Z/C/N flags. It then commits the result through the register file write port. This is the first stage in the core that both consumes and produces register file traffic.

## Interface
- `DATA_W`, 8, datapath and register width
- `ADDR_W`, 4, register address width (16 registers)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  unit idle and able to accept
- `opcode`  in  4  operation select
- `rd` / `rs1` / `rs2`  in  ADDR_W each  destination and source register addresses
- `imm`  in  DATA_W  immediate for LDI/ADDI
- `ra` / `rb`  out  ADDR_W each  register file read addresses
- `read_a` / `read_b`  in  DATA_W each  register file read data (combinational read)
- `wa`  out  ADDR_W  register file write address
- `wd`  out  DATA_W  register file write data
- `we`  out  1  register file write enable
- `flag_z` / `flag_c` / `flag_n`  out  1 each  registered status flags
- `done`  out  1  one-cycle pulse when an instruction retires
- `illegal`  out  1  one-cycle pulse on retire of an undefined opcode

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT (~A)
  - 7 SHL (A<<1)
  - 8 SHR (logical A>>1)
  - 9 MOV (A)
  - A LDI (imm)
  - B ADDI (A+imm)
  - C CMP (A−B, flags only)
  - D–F illegal
- A = `read_a` at `rs1`; B = `read_b` at `rs2`.
- FSM states IDLE → READ → EXEC → WB → IDLE. All transitions are unconditional except IDLE, which waits for the handshake.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `opcode`, `rd` and `imm`, load `ra`←`rs1` and `rb`←`rs2`, then go to READ. Inputs are ignored outside the handshake.
- READ: latch `read_a`/`read_b` into internal operand registers.
- EXEC: compute the result and register it into `wd`, load `wa`←`rd`, and update the flags.
- WB: `we`=1 for exactly this cycle if the op writes; `done`=1; `illegal`=1 if the opcode is D–F.
- Writes: NOP, CMP and illegal opcodes do not write. All other opcodes write `rd`.
- Flags:
  - NOP and illegal opcodes leave all flags unchanged.
  - All other ops set Z = (result==0) and N = result[7].
  - For CMP, "result" means the difference A−B, which is not written.
- C flag:
  - ADD/ADDI: bit 8 of the 9-bit sum.
  - SUB/CMP: borrow (1 iff A<B unsigned).
  - SHL: A[7]. SHR: A[0].
  - All other flag-updating ops: 0.
- All arithmetic is modulo 2^DATA_W. Because operands are latched, `rd`==`rs1`==`rs2` is legal.

## Timing
- Handshake at edge E0. Operands captured at E1. Result and flags visible after E2. `we`/`done` high during the E2–E3 cycle. Register file commits at E3.
- `in_ready` returns high after E3. Throughput is one instruction per 4 cycles.
- `ra`/`rb` hold their values from one handshake until the next.
- `wa`/`wd` hold after WB.
- `we`, `done` and `illegal` are 0 in every state except WB.
- Reset values: FSM=IDLE, `in_ready`=1 (combinational from IDLE), and all of `ra`, `rb`, `wa`, `wd`, `we`, flags, `done` and `illegal` = 0.
- Reset asserted in any state, including WB: next state is IDLE, `we`=0 from the following cycle, and the in-flight instruction is dropped with no retire pulse.
- `in_valid` held high while busy is not accepted. It is taken on the first IDLE cycle.

## Structure
- Package `alu_exec_pkg`: opcode localparams (OP_NOP … OP_CMP), FSM state encoding, and `DATA_W`/`ADDR_W` defaults.
- Sub-module `alu_core` (purely combinational):
  - Inputs: `opcode`, `A`, `B`, `imm`.
  - Outputs: `result`, `c`, `z`, `n`, `wr_en`, `flag_upd`, `illegal`.
- The top level holds the FSM and all registers.

## Test plan
- Reset, then LDI `rd`=3, `imm`=0x7F → `we` pulse with `wa`=3, `wd`=0x7F 3 cycles after the handshake; Z=0, N=0, C=0; `done` pulse coincident.
- ADD with `read_a`=0xFF, `read_b`=0x01 → `wd`=0x00, Z=1, C=1, N=0.
- CMP with A=0x10, B=0x20 → no `we`; C=1, N=1, Z=0; the register file is unchanged.
- Opcode 0xE → `illegal` and `done` pulse, `we`=0, flags unchanged from the prior instruction.
- `in_valid` held high continuously across two back-to-back instructions → the second is accepted exactly 4 cycles after the first; `ra`/`rb` update only at accept.
- `rst` asserted during WB of `ADD rd`=5 → `we` low on the next cycle, FSM in IDLE, all outputs at reset values, and a read of r5 shows the old value.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared widths, opcodes and FSM encoding for the execute stage
package alu_exec_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;
endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, Z/C/N, write and flag-update qualifiers
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result,
  output logic         c,
  output logic         z,
  output logic         n,
  output logic         wr_en,
  output logic         flag_upd,
  output logic         illegal
);

  logic [W:0] ext;

  always_comb begin
    ext      = '0;
    result   = '0;
    c        = 1'b0;
    wr_en    = 1'b1;
    flag_upd = 1'b1;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP: begin
        wr_en    = 1'b0;
        flag_upd = 1'b0;
      end
      OP_ADD: begin
        ext    = {1'b0, A} + {1'b0, B};
        result = ext[W-1:0];
        c      = ext[W];
      end
      // The extra bit of a widened subtract is the unsigned borrow.
      OP_SUB, OP_CMP: begin
        ext    = {1'b0, A} - {1'b0, B};
        result = ext[W-1:0];
        c      = ext[W];
        wr_en  = (opcode != OP_CMP);
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_NOT: result = ~A;
      OP_SHL: begin
        result = {A[W-2:0], 1'b0};
        c      = A[W-1];
      end
      OP_SHR: begin
        result = {1'b0, A[W-1:1]};
        c      = A[0];
      end
      OP_MOV: result = A;
      OP_LDI: result = imm;
      OP_ADDI: begin
        ext    = {1'b0, A} + {1'b0, imm};
        result = ext[W-1:0];
        c      = ext[W];
      end
      default: begin
        wr_en    = 1'b0;
        flag_upd = 1'b0;
        illegal  = 1'b1;
      end
    endcase
  end

  assign z = (result == '0);
  assign n = result[W-1];

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - four-state execute/writeback stage in front of a 2R1W register file
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] ra,
  output logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] read_a,
  input  logic [DATA_W-1:0] read_b,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              done,
  output logic              illegal
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              fz_q, fz_d, fc_q, fc_d, fn_q, fn_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_c, alu_z, alu_n, alu_wr, alu_upd, alu_ill;

  alu_core #(.W(DATA_W)) u_alu (
    .opcode   (op_q),
    .A        (a_q),
    .B        (b_q),
    .imm      (imm_q),
    .result   (alu_result),
    .c        (alu_c),
    .z        (alu_z),
    .n        (alu_n),
    .wr_en    (alu_wr),
    .flag_upd (alu_upd),
    .illegal  (alu_ill)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    a_d       = a_q;
    b_d       = b_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    fz_d      = fz_q;
    fc_d      = fc_q;
    fn_d      = fn_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          rd_d    = rd;
          imm_d   = imm;
          ra_d    = rs1;
          rb_d    = rs2;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        a_d     = read_a;
        b_d     = read_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wd_d      = alu_result;
        wa_d      = rd_q;
        we_d      = alu_wr;
        done_d    = 1'b1;
        illegal_d = alu_ill;
        if (alu_upd) begin
          fz_d = alu_z;
          fc_d = alu_c;
          fn_d = alu_n;
        end
        state_d = ST_WB;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      fz_q      <= 1'b0;
      fc_q      <= 1'b0;
      fn_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      a_q       <= a_d;
      b_q       <= b_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      fz_q      <= fz_d;
      fc_q      <= fc_d;
      fn_q      <= fn_d;
    end
  end

  // Reset landing in WB must also stop the register file from committing at that edge.
  assign we       = we_q & ~rst;
  assign done     = done_q & ~rst;
  assign illegal  = illegal_q & ~rst;
  assign in_ready = (state_q == ST_IDLE);
  assign ra       = ra_q;
  assign rb       = rb_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;
  assign flag_n   = fn_q;

endmodule
